// File: rtl/sd_pkg.sv
// Shared sigma-delta package: common sample-format constants, the CIC
// datapath width rule and the 8-bit saturation helper. Used by both the
// modulator and the sinc^2 decimator.
package sd_pkg;

  localparam int SD_SAMPLE_W   = 8;
  localparam int SD_SAMPLE_MIN = -128;
  localparam int SD_SAMPLE_MAX = 127;

  // A sinc^2 filter with ratio 2^log2r peaks at R^2 = 2^(2*log2r), so one
  // extra bit holds the full-scale value without wrapping.
  function automatic int sd_cic_w(input int log2r);
    return 2 * log2r + 1;
  endfunction

  function automatic logic signed [SD_SAMPLE_W-1:0] sd_sat8(input int v);
    int r;
    if (v > SD_SAMPLE_MAX)      r = SD_SAMPLE_MAX;
    else if (v < SD_SAMPLE_MIN) r = SD_SAMPLE_MIN;
    else                        r = v;
    return r[SD_SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/sd_comb_stage.sv
// One CIC comb (differentiator) section.
//   clk, clrn : clock, async active-low reset
//   tick      : decimated-rate strobe; delay register loads x when high
//   x         : W-bit input
//   y         : x minus the value x held on the previous tick (modulo 2^W)
module sd_comb_stage #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         tick,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)     d_q <= '0;
    else if (tick) d_q <= x;
  end

  assign y = x - d_q;

endmodule

// File: rtl/sinc2_decimator.sv
// Second-order CIC (sinc^2) decimator for a 1-bit sigma-delta stream.
// Decimates by R = 2^LOG2R and rescales to an 8-bit signed sample.
//   clk, clrn : clock, async active-low reset
//   en        : bit strobe, din accepted only on edges with en=1
//   din       : modulator bitstream (1 = +full scale, 0 = -full scale)
//   sample    : signed decimated sample, held between outputs
//   valid     : one-cycle pulse when sample/raw are new
//   raw       : unsigned comb output captured alongside sample
module sinc2_decimator
  import sd_pkg::*;
#(
  parameter  int LOG2R = 6,
  localparam int W     = sd_cic_w(LOG2R)
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          en,
  input  logic                          din,
  output logic signed [SD_SAMPLE_W-1:0] sample,
  output logic                          valid,
  output logic [W-1:0]                  raw
);

  // c2 spans 0..2^(2*LOG2R); this shift maps that range onto 0..256.
  localparam int SH = 2 * LOG2R - 8;

  logic [W-1:0]       int1_q, int2_q, int1_d;
  logic [LOG2R-1:0]   cnt_q;
  logic               tick_q, tick2_q;
  logic [1:0]         wu_q;
  logic [W-1:0]       c1, c2, c2_q;
  logic [W-1:0]       raw_q;
  logic signed [SD_SAMPLE_W-1:0] sample_q, sample_d;
  logic               valid_q;
  logic [31:0]        c2_ext;
  int                 s_full;

  assign int1_d = int1_q + {{(W-1){1'b0}}, din};

  // Integrators and frame counter; wrap-around is intended (CIC arithmetic).
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      int1_q <= '0;
      int2_q <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= en && (&cnt_q);
      if (en) begin
        int1_q <= int1_d;
        int2_q <= int2_q + int1_d;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  sd_comb_stage #(.W(W)) u_comb1 (
    .clk(clk), .clrn(clrn), .tick(tick_q), .x(int2_q), .y(c1)
  );

  sd_comb_stage #(.W(W)) u_comb2 (
    .clk(clk), .clrn(clrn), .tick(tick_q), .x(c1), .y(c2)
  );

  // Rescale: c2 is non-negative, so a zero-extended int is wide enough
  // to hold the signed W+1-bit result exactly.
  assign c2_ext   = 32'(c2_q);
  assign s_full   = int'(c2_ext >> SH) - (SD_SAMPLE_MAX + 1);
  assign sample_d = sd_sat8(s_full);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      c2_q     <= '0;
      tick2_q  <= 1'b0;
      wu_q     <= '0;
      raw_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      tick2_q <= tick_q;
      valid_q <= 1'b0;
      if (tick_q) c2_q <= c2;
      if (tick2_q) begin
        // The first two frames only fill the comb delays; drop them.
        if (wu_q == 2'd2) begin
          raw_q    <= c2_q;
          sample_q <= sample_d;
          valid_q  <= 1'b1;
        end else begin
          wu_q <= wu_q + 2'd1;
        end
      end
    end
  end

  assign sample = sample_q;
  assign raw    = raw_q;
  assign valid  = valid_q;

endmodule
